// File: rtl/mem_responder.sv
// Memory-side responder for a packed put/get port: performs loads and byte-masked
// stores on internal word storage and returns one in-order response per request.
module mem_responder #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int RESP_DEPTH    = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        put_valid,
    input  logic [67:0] put_request,
    output logic        put_ready,
    input  logic        get_valid,
    output logic        get_ready,
    output logic [67:0] get_response
);

    localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CW = $clog2(RESP_DEPTH + 1);

    logic [31:0] storage [2**ADDRESS_WIDTH];
    logic [67:0] fifo    [RESP_DEPTH];

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    logic [3:0]               byte_en;
    logic [31:0]              addr, data, merged;
    logic [ADDRESS_WIDTH-1:0] word_idx;
    logic                     push, pop;
    logic                     unused_addr_bits;

    assign byte_en  = put_request[67:64];
    assign addr     = put_request[63:32];
    assign data     = put_request[31:0];
    assign word_idx = addr[ADDRESS_WIDTH+1:2];

    // Byte offset and bits above the word index are don't-care: high addresses alias.
    assign unused_addr_bits = ^{addr[1:0], addr[31:ADDRESS_WIDTH+2]};

    // A load has byte_en == 0, so merged degenerates to the stored word.
    always_comb begin
        merged = storage[word_idx];
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) merged[8*i +: 8] = data[8*i +: 8];
        end
    end

    // Credits depend only on registered occupancy, never on the handshake inputs.
    assign put_ready    = !RST && (count < CW'(RESP_DEPTH));
    assign get_ready    = (count != '0);
    assign get_response = get_ready ? fifo[rd_ptr] : '0;

    assign push = put_valid && put_ready;
    assign pop  = get_valid && get_ready;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage is deliberately not reset; put_ready already blocks writes during RST.
    always_ff @(posedge CLK) begin
        if (push && (byte_en != 4'b0000)) storage[word_idx] <= merged;
    end

    // The FIFO slot write is the registered storage read (single in-flight stage).
    always_ff @(posedge CLK) begin
        if (push) fifo[wr_ptr] <= {byte_en, addr, merged};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: scoreboard queue of expected responses,
// checked with immediate assertions as the DUT presents them.
module tb_mem_responder;

    logic        CLK = 1'b0;
    logic        RST;
    logic        put_valid;
    logic [67:0] put_request;
    logic        put_ready;
    logic        get_valid;
    logic        get_ready;
    logic [67:0] get_response;

    mem_responder #(.ADDRESS_WIDTH(16), .RESP_DEPTH(2)) dut (
        .CLK(CLK), .RST(RST),
        .put_valid(put_valid), .put_request(put_request), .put_ready(put_ready),
        .get_valid(get_valid), .get_ready(get_ready), .get_response(get_response)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    logic [67:0] sb [$];
    logic [31:0] mdl [int];

    task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        if (be[0]) r[7:0]   = d[7:0];
        if (be[1]) r[15:8]  = d[15:8];
        if (be[2]) r[23:16] = d[23:16];
        if (be[3]) r[31:24] = d[31:24];
        return r;
    endfunction

    // Record an accepted request in the model and push its expected response.
    task automatic issue(input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
        int k;
        logic [31:0] old, nw;
        k   = int'(a[17:2]);
        old = mdl.exists(k) ? mdl[k] : 32'h0;
        nw  = merge(old, d, be);
        if (be != 4'h0) mdl[k] = nw;
        sb.push_back({be, a, nw});
    endtask

    task automatic put(input logic [3:0] be, input logic [31:0] a, input logic [31:0] d,
                       input string tag);
        put_valid   = 1'b1;
        put_request = {be, a, d};
        for (int i = 0; i < 20 && !put_ready; i++) @(negedge CLK);
        check({tag, "_prdy"}, {67'b0, put_ready}, 68'd1);
        if (put_ready) issue(be, a, d);
        @(negedge CLK);
        put_valid = 1'b0;
    endtask

    task automatic get(input string tag);
        get_valid = 1'b1;
        for (int i = 0; i < 20 && !get_ready; i++) @(negedge CLK);
        check({tag, "_grdy"}, {67'b0, get_ready}, 68'd1);
        if (get_ready && sb.size() > 0) check(tag, get_response, sb.pop_front());
        @(negedge CLK);
        get_valid = 1'b0;
    endtask

    initial begin
        int acc, sent, recv;
        logic rdy_low;

        RST = 1'b1; put_valid = 1'b0; get_valid = 1'b0; put_request = '0;
        repeat (2) @(negedge CLK);
        check("rst_prdy", {67'b0, put_ready}, 68'd0);
        check("rst_grdy", {67'b0, get_ready}, 68'd0);
        RST = 1'b0;
        #1;
        check("idle_prdy", {67'b0, put_ready}, 68'd1);
        check("idle_grdy", {67'b0, get_ready}, 68'd0);
        check("idle_resp", get_response, 68'd0);
        @(negedge CLK);

        // Full-word store then load, with one-cycle latency checks.
        put(4'hF, 32'h10, 32'hDEADBEEF, "st_full");
        check("st_full_lat", {67'b0, get_ready}, 68'd1);
        get("st_full_resp");
        put(4'h0, 32'h10, 32'h0, "ld_full");
        check("ld_full_lat", {67'b0, get_ready}, 68'd1);
        check("ld_full_const", get_response, {4'h0, 32'h10, 32'hDEADBEEF});
        get("ld_full_resp");

        // Partial store merges lanes 0 and 2.
        put(4'b0101, 32'h10, 32'h11223344, "st_part");
        check("st_part_const", get_response, {4'b0101, 32'h10, 32'hDE22BE44});
        get("st_part_resp");
        put(4'h0, 32'h10, 32'h0, "ld_part");
        check("ld_part_const", get_response, {4'h0, 32'h10, 32'hDE22BE44});
        get("ld_part_resp");

        // Backpressure: no pops, five offered stores, only RESP_DEPTH accepted.
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            logic [31:0] a, d;
            a = 32'h20 + 32'(acc) * 4;
            d = 32'hA0 + 32'(acc);
            put_valid   = 1'b1;
            put_request = {4'hF, a, d};
            if (put_ready) begin
                issue(4'hF, a, d);
                acc++;
            end
            @(negedge CLK);
        end
        put_valid = 1'b0;
        check("bp_accepts", 68'(acc), 68'd2);
        check("bp_prdy_low", {67'b0, put_ready}, 68'd0);
        get("bp_resp0");
        check("bp_credit", {67'b0, put_ready}, 68'd1);
        get("bp_resp1");

        // Back-to-back: 100 loads with both sides always ready.
        put(4'hF, 32'h1000, 32'h5A5AA5A5, "bb_seed");
        get("bb_seed_resp");
        sent = 0; recv = 0; rdy_low = 1'b0;
        for (int c = 0; c < 101; c++) begin
            get_valid = 1'b1;
            if (sent < 100) begin
                put_valid   = 1'b1;
                put_request = {4'h0, 32'h1000, 32'h0};
                if (!put_ready) rdy_low = 1'b1;
                else begin
                    issue(4'h0, 32'h1000, 32'h0);
                    sent++;
                end
            end else begin
                put_valid = 1'b0;
            end
            if (get_ready && sb.size() > 0) begin
                check("bb_resp", get_response, sb.pop_front());
                recv++;
            end
            @(negedge CLK);
        end
        put_valid = 1'b0; get_valid = 1'b0;
        check("bb_sent", 68'(sent), 68'd100);
        check("bb_recv", 68'(recv), 68'd100);
        check("bb_prdy_low", {67'b0, rdy_low}, 68'd0);
        check("bb_drained", {67'b0, get_ready}, 68'd0);

        // Aliasing: bit 18 lies above the word index and is ignored.
        put(4'hF, 32'h40000, 32'hCAFEF00D, "alias_st");
        get("alias_st_resp");
        put(4'h0, 32'h0, 32'h0, "alias_ld");
        check("alias_const", get_response, {4'h0, 32'h0, 32'hCAFEF00D});
        get("alias_ld_resp");

        // Reset with two responses queued discards them.
        put(4'h0, 32'h10, 32'h0, "rq0");
        put(4'h0, 32'h0, 32'h0, "rq1");
        check("rq_full", {67'b0, put_ready}, 68'd0);
        RST = 1'b1;
        #1;
        check("mid_rst_prdy", {67'b0, put_ready}, 68'd0);
        @(negedge CLK);
        RST = 1'b0;
        sb.delete();
        #1;
        check("post_rst_grdy", {67'b0, get_ready}, 68'd0);
        check("post_rst_resp", get_response, 68'd0);
        check("post_rst_prdy", {67'b0, put_ready}, 68'd1);
        @(negedge CLK);
        put(4'h0, 32'h10, 32'h0, "post_ld");
        get("post_ld_resp");
        check("post_ld_empty", {67'b0, get_ready}, 68'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
